rv_writeback: RTL and testbench

- Final pipeline stage of the uRV core. It sits directly downstream of the execute stage.
- It consumes the registered w_* bundle from execute and waits for data-memory completion of loads and stores.
- It aligns and sign/zero-extends load data, then drives the register-file write port.
- It raises a stall request while a memory access is outstanding, so execute and earlier stages hold.

---
 rtl/rv_writeback_if.sv | 29 ++
 rtl/rv_writeback.sv | 134 +++++++++++++
 tb/tb_rv_writeback.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv_writeback_if.sv
// rtl/rv_writeback_if.sv - execute/data-memory/register-file bundle seen by the writeback stage
interface rv_writeback_if;
    logic [2:0]  w_fun_i;
    logic        w_load_i;
    logic        w_store_i;
    logic [4:0]  w_rd_i;
    logic [31:0] w_rd_value_i;
    logic        w_rd_write_i;
    logic [31:0] w_dm_addr_i;
    logic [31:0] dm_data_l_i;
    logic        dm_load_done_i;
    logic        dm_store_done_i;
    logic        w_stall_req_o;
    logic        rf_rd_write_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;

    modport master (
        output w_fun_i, w_load_i, w_store_i, w_rd_i, w_rd_value_i, w_rd_write_i,
               w_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        input  w_stall_req_o, rf_rd_write_o, rf_rd_o, rf_rd_value_o
    );

    modport slave (
        input  w_fun_i, w_load_i, w_store_i, w_rd_i, w_rd_value_i, w_rd_write_i,
               w_dm_addr_i, dm_data_l_i, dm_load_done_i, dm_store_done_i,
        output w_stall_req_o, rf_rd_write_o, rf_rd_o, rf_rd_value_o
    );
endinterface

// File: rtl/rv_writeback.sv
// rtl/rv_writeback.sv - writeback stage: waits for data memory, aligns load data, drives the rf write port
module rv_writeback #(
    parameter bit g_write_r0 = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rv_writeback_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT_LD = 2'd1, ST_WAIT_ST = 2'd2} state_t;

    state_t      r_state, w_next_state;
    logic [2:0]  r_fun;
    logic [4:0]  r_rd;
    logic        r_rd_write;
    logic [1:0]  r_addr_lo;
    logic        r_rf_write;
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_value;

    logic        w_latch, w_wr, w_wr_en, w_stall;
    logic [4:0]  w_wr_rd;
    logic [31:0] w_wr_value;
    logic [2:0]  w_ld_fun;
    logic [1:0]  w_ld_addr;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld_value;
    logic        w_unused_addr;

    assign w_unused_addr = ^bus.w_dm_addr_i[31:2];

    // In WAIT_LD execute drives its bundle inactive, so decode from the latched copy
    always_comb begin
        w_ld_fun  = (r_state == ST_WAIT_LD) ? r_fun     : bus.w_fun_i;
        w_ld_addr = (r_state == ST_WAIT_LD) ? r_addr_lo : bus.w_dm_addr_i[1:0];
        case (w_ld_addr)
            2'b00:   w_byte = bus.dm_data_l_i[7:0];
            2'b01:   w_byte = bus.dm_data_l_i[15:8];
            2'b10:   w_byte = bus.dm_data_l_i[23:16];
            default: w_byte = bus.dm_data_l_i[31:24];
        endcase
        w_half = w_ld_addr[1] ? bus.dm_data_l_i[31:16] : bus.dm_data_l_i[15:0];
        case (w_ld_fun)
            3'b000:  w_ld_value = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ld_value = {{16{w_half[15]}}, w_half};
            3'b010:  w_ld_value = bus.dm_data_l_i;
            3'b100:  w_ld_value = {24'h0, w_byte};
            3'b101:  w_ld_value = {16'h0, w_half};
            default: w_ld_value = 32'h0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_wr         = 1'b0;
        w_stall      = 1'b0;
        w_wr_rd      = bus.w_rd_i;
        w_wr_value   = bus.w_rd_value_i;
        case (r_state)
            ST_IDLE: begin
                if (bus.w_load_i) begin
                    if (bus.dm_load_done_i) begin
                        w_wr       = bus.w_rd_write_i;
                        w_wr_value = w_ld_value;
                    end else begin
                        w_stall      = 1'b1;
                        w_latch      = 1'b1;
                        w_next_state = ST_WAIT_LD;
                    end
                end else if (bus.w_store_i) begin
                    if (!bus.dm_store_done_i) begin
                        w_stall      = 1'b1;
                        w_next_state = ST_WAIT_ST;
                    end
                end else begin
                    w_wr = bus.w_rd_write_i;
                end
            end
            ST_WAIT_LD: begin
                w_wr_rd    = r_rd;
                w_wr_value = w_ld_value;
                if (bus.dm_load_done_i) begin
                    w_wr         = r_rd_write;
                    w_next_state = ST_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            ST_WAIT_ST: begin
                if (bus.dm_store_done_i) w_next_state = ST_IDLE;
                else                     w_stall      = 1'b1;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    assign w_wr_en = w_wr && (g_write_r0 || (w_wr_rd != 5'd0));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_fun      <= 3'd0;
            r_rd       <= 5'd0;
            r_rd_write <= 1'b0;
            r_addr_lo  <= 2'd0;
            r_rf_write <= 1'b0;
            r_rf_rd    <= 5'd0;
            r_rf_value <= 32'h0;
        end else begin
            r_state    <= w_next_state;
            r_rf_write <= w_wr_en;
            if (w_latch) begin
                r_fun      <= bus.w_fun_i;
                r_rd       <= bus.w_rd_i;
                r_rd_write <= bus.w_rd_write_i;
                r_addr_lo  <= bus.w_dm_addr_i[1:0];
            end
            if (w_wr_en) begin
                r_rf_rd    <= w_wr_rd;
                r_rf_value <= w_wr_value;
            end
        end
    end

    assign bus.w_stall_req_o = w_stall;
    assign bus.rf_rd_write_o = r_rf_write;
    assign bus.rf_rd_o       = r_rf_rd;
    assign bus.rf_rd_value_o = r_rf_value;

    // Simultaneous load and store is an upstream bug; the load wins in the FSM
    a_no_load_and_store: assert property (@(posedge clk_i) disable iff (rst_i)
        !((r_state == ST_IDLE) && bus.w_load_i && bus.w_store_i));
endmodule

// File: tb/tb_rv_writeback.sv
// tb/tb_rv_writeback.sv - randomized self-checking bench for rv_writeback with both g_write_r0 settings
module tb_rv_writeback;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rv_writeback_if if0 ();
    rv_writeback_if if1 ();

    assign if1.w_fun_i         = if0.w_fun_i;
    assign if1.w_load_i        = if0.w_load_i;
    assign if1.w_store_i       = if0.w_store_i;
    assign if1.w_rd_i          = if0.w_rd_i;
    assign if1.w_rd_value_i    = if0.w_rd_value_i;
    assign if1.w_rd_write_i    = if0.w_rd_write_i;
    assign if1.w_dm_addr_i     = if0.w_dm_addr_i;
    assign if1.dm_data_l_i     = if0.dm_data_l_i;
    assign if1.dm_load_done_i  = if0.dm_load_done_i;
    assign if1.dm_store_done_i = if0.dm_store_done_i;

    rv_writeback #(.g_write_r0(1'b0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(if0.slave));
    rv_writeback #(.g_write_r0(1'b1)) dut1 (.clk_i(clk), .rst_i(rst), .bus(if1.slave));

    int n_checks = 0;
    int n_errors = 0;
    logic [4:0]  m_rd[2];
    logic [31:0] m_val[2];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(logic [2:0] fun, logic [31:0] addr, logic [31:0] data);
        logic [31:0] b, h;
        b = (data >> (8 * addr[1:0])) & 32'hFF;
        h = (data >> (16 * addr[1])) & 32'hFFFF;
        case (fun)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return data;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    task automatic check_outputs(string tag);
        check({tag, ".we0"},  {31'h0, if0.rf_rd_write_o}, 0);
        check({tag, ".we1"},  {31'h0, if1.rf_rd_write_o}, 0);
    endtask

    task automatic check_rf(string tag, logic [1:0] exp_we);
        check({tag, ".we0"},  {31'h0, if0.rf_rd_write_o}, {31'h0, exp_we[0]});
        check({tag, ".we1"},  {31'h0, if1.rf_rd_write_o}, {31'h0, exp_we[1]});
        check({tag, ".rd0"},  {27'h0, if0.rf_rd_o}, {27'h0, m_rd[0]});
        check({tag, ".rd1"},  {27'h0, if1.rf_rd_o}, {27'h0, m_rd[1]});
        check({tag, ".val0"}, if0.rf_rd_value_o, m_val[0]);
        check({tag, ".val1"}, if1.rf_rd_value_o, m_val[1]);
    endtask

    task automatic drive_inactive();
        if0.w_fun_i         = 3'd0;
        if0.w_load_i        = 1'b0;
        if0.w_store_i       = 1'b0;
        if0.w_rd_i          = 5'd0;
        if0.w_rd_value_i    = 32'h0;
        if0.w_rd_write_i    = 1'b0;
        if0.w_dm_addr_i     = 32'h0;
        if0.dm_data_l_i     = $urandom;
        if0.dm_load_done_i  = 1'b0;
        if0.dm_store_done_i = 1'b0;
    endtask

    // kind: 0 = ALU, 1 = load, 2 = store, 3 = bubble with stray done strobes
    task automatic do_txn(int kind, logic [2:0] fun, logic [4:0] rd, logic rdw, logic [31:0] addr,
                          logic [31:0] val, logic [31:0] data, int delay, string tag);
        bit mem;
        int last;
        logic [1:0] exp_we;
        mem  = (kind == 1) || (kind == 2);
        last = mem ? delay : 0;
        for (int c = 0; c <= last; c++) begin
            drive_inactive();
            if (c == 0) begin
                if0.w_fun_i      = fun;
                if0.w_rd_i       = rd;
                if0.w_rd_write_i = (kind == 3) ? 1'b0 : rdw;
                if0.w_dm_addr_i  = addr;
                if0.w_rd_value_i = val;
                if0.w_load_i     = (kind == 1);
                if0.w_store_i    = (kind == 2);
            end
            if (kind == 1) begin
                if0.dm_load_done_i  = (c == last);
                if0.dm_store_done_i = 1'($urandom_range(0, 1));
                if (c == last) if0.dm_data_l_i = data;
            end else if (kind == 2) begin
                if0.dm_store_done_i = (c == last);
                if0.dm_load_done_i  = 1'($urandom_range(0, 1));
            end else begin
                if0.dm_load_done_i  = 1'($urandom_range(0, 1));
                if0.dm_store_done_i = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            check({tag, ".stall0"}, {31'h0, if0.w_stall_req_o}, {31'h0, 1'(mem && (c < delay))});
            check({tag, ".stall1"}, {31'h0, if1.w_stall_req_o}, {31'h0, 1'(mem && (c < delay))});
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                exp_we[i] = (c == last) && (kind == 0 || kind == 1) && rdw && (rd != 0 || i == 1);
                if (exp_we[i]) begin
                    m_rd[i]  = rd;
                    m_val[i] = (kind == 1) ? ref_load(fun, addr, data) : val;
                end
            end
            check_rf(tag, exp_we);
        end
        drive_inactive();
    endtask

    initial begin
        int kind;
        m_rd  = '{5'd0, 5'd0};
        m_val = '{32'h0, 32'h0};
        drive_inactive();
        #3;
        check_rf("reset", 2'b00);
        check("reset.stall", {31'h0, if0.w_stall_req_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        do_txn(0, 3'd0, 5'd5, 1'b1, 32'h0,     32'h1234_5678, 32'h0,         0, "alu");
        do_txn(1, 3'd0, 5'd7, 1'b1, 32'h103,   32'h0,         32'h80FF_0000, 0, "lb_nowait");
        do_txn(1, 3'd5, 5'd9, 1'b1, 32'h202,   32'h0,         32'hBEEF_1111, 3, "lhu_wait3");
        do_txn(2, 3'd2, 5'd0, 1'b0, 32'h40,    32'h0,         32'h0,         2, "store_wait2");
        do_txn(0, 3'd0, 5'd3, 1'b1, 32'h0,     32'hA5A5_0001, 32'h0,         0, "alu_after_st");
        do_txn(1, 3'd2, 5'd0, 1'b1, 32'h44,    32'h0,         32'hCAFE_F00D, 1, "lw_x0");
        do_txn(3, 3'd0, 5'd0, 1'b0, 32'h0,     32'h0,         32'h0,         0, "stray_idle");

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 3);
            do_txn(kind, 3'($urandom_range(0, 7)),
                   ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                   1'($urandom_range(0, 3) != 0), $urandom, $urandom, $urandom,
                   $urandom_range(0, 4), "rand");
        end

        // Asynchronous reset in the middle of a load wait
        if0.w_load_i     = 1'b1;
        if0.w_fun_i      = 3'd2;
        if0.w_rd_i       = 5'd12;
        if0.w_rd_write_i = 1'b1;
        @(posedge clk);
        #1;
        drive_inactive();
        check("rst_mid.stall_before", {31'h0, if0.w_stall_req_o}, 1);
        #2;
        rst = 1'b1;
        #1;
        m_rd  = '{5'd0, 5'd0};
        m_val = '{32'h0, 32'h0};
        check("rst_mid.stall0", {31'h0, if0.w_stall_req_o}, 0);
        check("rst_mid.stall1", {31'h0, if1.w_stall_req_o}, 0);
        check_rf("rst_mid", 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        if0.dm_load_done_i = 1'b1;
        if0.dm_data_l_i    = 32'h1111_2222;
        @(negedge clk);
        check("stray_ld.stall", {31'h0, if0.w_stall_req_o}, 0);
        @(posedge clk);
        #1;
        check_rf("stray_ld", 2'b00);
        drive_inactive();
        do_txn(0, 3'd0, 5'd1, 1'b1, 32'h0, 32'h0BAD_BEEF, 32'h0, 0, "alu_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
